key_encoder: RTL and testbench

Front-panel key encoder for the piano: synchronises and debounces the eight key switches and the upper-bank select, then encodes the result into a 4-bit note index. It produces press/release pulses and a held level. It sits between the board switches and the note/track player, and is the input-side counterpart of the one-hot LED driver that displays a 4-bit track index.

---
 rtl/key_encoder.sv | 178 +++++++++++++++++
 tb/tb_key_encoder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_encoder.sv
// key_encoder
//   Front-panel key encoder for the piano. Synchronises and debounces the
//   eight key switches plus the upper-bank select, then encodes the lowest
//   pressed key into a 4-bit note index {bank, position}. Produces
//   one-cycle press/release pulses and a held-level flag. All outputs are
//   registered.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   key_in[7:0]   raw key switches (bit i = key i), asynchronous to clk
//   higher_8_sel  raw bank select, asynchronous; 1 selects notes 8-15
//   key_index     {bank, key position} of the currently held note
//   key_valid     high while a note is held
//   key_press     one-cycle pulse when a new note index becomes held
//   key_release   one-cycle pulse when the held note ends or is replaced
//   multi_key     high while two or more keys are stable-pressed
//
// Configuration
//   KEY_MULTI_ERR_EN  when defined, two or more stable keys raise multi_key
//                     and count as "no key"; when undefined the lowest key
//                     wins and multi_key stays 0.
//
// Parameters
//   DEBOUNCE_CYCLES   cycles a synchronised vector must stay unchanged
//                     before it is accepted (1 .. 2^24-1)

module key_encoder #(
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_in,
  input  logic       higher_8_sel,
  output logic [3:0] key_index,
  output logic       key_valid,
  output logic       key_press,
  output logic       key_release,
  output logic       multi_key
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic {
    IDLE,
    HELD
  } state_t;

  logic [8:0]    sync_meta;
  logic [8:0]    sync_vec;
  logic [8:0]    candidate;
  logic [8:0]    stable_vec;
  logic [CW-1:0] count;

  logic [2:0]    pos;
  logic [3:0]    new_index;
  logic          key_present;
  logic          multi_next;

  state_t        state;
  state_t        state_next;
  logic [3:0]    index_next;
  logic          valid_next;
  logic          press_next;
  logic          release_next;

  // Two-flop synchroniser for the whole raw vector, bank select on top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= '0;
      sync_vec  <= '0;
    end else begin
      sync_meta <= {higher_8_sel, key_in};
      sync_vec  <= sync_meta;
    end
  end

  // Debounce filter: any change restarts the count on the new candidate.
  // The candidate is accepted exactly once, when the count hits its last
  // value; the counter then keeps running up to saturation so it never
  // passes through that value again for the same candidate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      candidate  <= '0;
      count      <= '0;
      stable_vec <= '0;
    end else if (sync_vec != candidate) begin
      candidate <= sync_vec;
      count     <= '0;
    end else begin
      if (count != CNT_MAX) begin
        count <= count + CW'(1);
      end
      if (count == CNT_LAST) begin
        stable_vec <= candidate;
      end
    end
  end

  // Priority encoder: loop runs high to low so the lowest set bit is the
  // last assignment and therefore wins.
  always_comb begin
    pos = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (stable_vec[i]) begin
        pos = 3'(i);
      end
    end
  end

  assign new_index = {stable_vec[8], pos};

`ifdef KEY_MULTI_ERR_EN
  // v & (v-1) clears the lowest set bit; anything left means 2+ keys.
  logic multi_det;
  assign multi_det   = (stable_vec[7:0] & (stable_vec[7:0] - 8'd1)) != 8'd0;
  assign key_present = (stable_vec[7:0] != 8'd0) && !multi_det;
  assign multi_next  = multi_det;
`else
  assign key_present = (stable_vec[7:0] != 8'd0);
  assign multi_next  = 1'b0;
`endif

  // Next-state and next-output logic. A different index while held is
  // reported as release and press in the same cycle.
  always_comb begin
    state_next   = state;
    index_next   = key_index;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state)
      IDLE: begin
        if (key_present) begin
          state_next = HELD;
          index_next = new_index;
          press_next = 1'b1;
        end
      end
      HELD: begin
        if (!key_present) begin
          state_next   = IDLE;
          release_next = 1'b1;
        end else if (new_index != key_index) begin
          index_next   = new_index;
          press_next   = 1'b1;
          release_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    valid_next = (state_next == HELD);
  end

  // State and registered outputs. Reset clears everything without
  // producing a release pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      key_index   <= 4'd0;
      key_valid   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      multi_key   <= 1'b0;
    end else begin
      state       <= state_next;
      key_index   <= index_next;
      key_valid   <= valid_next;
      key_press   <= press_next;
      key_release <= release_next;
      multi_key   <= multi_next;
    end
  end

endmodule

// File: tb/tb_key_encoder.sv
// tb_key_encoder
//   Self-checking bench for key_encoder with DEBOUNCE_CYCLES = 4.
//   A behavioural model tracks the synchronised input history and accepts
//   a vector once it has been seen unchanged for DEBOUNCE_CYCLES+1
//   consecutive synchronised samples; the FSM outputs are derived from the
//   accepted vector. A compare process checks every cycle, and directed
//   scenarios add hand-computed literal expectations.

module tb_key_encoder;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] key_in = 8'h00;
  logic       higher_8_sel = 1'b0;
  logic [3:0] key_index;
  logic       key_valid;
  logic       key_press;
  logic       key_release;
  logic       multi_key;

  int  checks = 0;
  int  passes = 0;
  int  press_cnt = 0;
  int  release_cnt = 0;
  bit  armed = 1'b0;

  // Model state
  logic [8:0] m_rawq[$];
  logic [8:0] m_hist[$];
  logic [8:0] m_stable;
  bit         m_held;
  logic [3:0] m_idx;
  bit         m_valid;
  bit         m_press;
  bit         m_release;
  bit         m_multi;

  always #5 clk = ~clk;

  key_encoder #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .higher_8_sel(higher_8_sel),
    .key_index   (key_index),
    .key_valid   (key_valid),
    .key_press   (key_press),
    .key_release (key_release),
    .multi_key   (multi_key)
  );

  function automatic logic [2:0] lowestKey(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  task automatic modelReset();
    m_rawq    = '{9'd0, 9'd0};
    m_hist    = '{9'd0};
    m_stable  = 9'd0;
    m_held    = 1'b0;
    m_idx     = 4'd0;
    m_valid   = 1'b0;
    m_press   = 1'b0;
    m_release = 1'b0;
    m_multi   = 1'b0;
  endtask

  task automatic modelStep(input logic [8:0] raw);
    logic [8:0] s;
    int         ones;
    bit         present;
    bit         all_eq;
    logic [3:0] idx_new;
    ones = $countones(m_stable[7:0]);
`ifdef KEY_MULTI_ERR_EN
    present = (ones == 1);
    m_multi = (ones >= 2);
`else
    present = (ones >= 1);
    m_multi = 1'b0;
`endif
    idx_new   = {m_stable[8], lowestKey(m_stable[7:0])};
    m_press   = 1'b0;
    m_release = 1'b0;
    if (present && !m_held) begin
      m_press = 1'b1;
      m_held  = 1'b1;
      m_idx   = idx_new;
    end else if (!present && m_held) begin
      m_release = 1'b1;
      m_held    = 1'b0;
    end else if (present && m_held && (idx_new != m_idx)) begin
      m_press   = 1'b1;
      m_release = 1'b1;
      m_idx     = idx_new;
    end
    m_valid = m_held;
    // Raw input appears at the filter two samples later.
    s = m_rawq.pop_front();
    m_rawq.push_back(raw);
    m_hist.push_back(s);
    while (m_hist.size() > DEB + 1) m_hist.delete(0);
    if (m_hist.size() == DEB + 1) begin
      all_eq = 1'b1;
      foreach (m_hist[i]) if (m_hist[i] != s) all_eq = 1'b0;
      if (all_eq) m_stable = s;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) modelReset();
    else     modelStep({higher_8_sel, key_in});
  end

  task automatic checkOutput(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic checkCount(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (armed && !rst) begin
      checkOutput("cmp_key_index",   key_index,   m_idx);
      checkOutput("cmp_key_valid",   {3'b0, key_valid},   {3'b0, m_valid});
      checkOutput("cmp_key_press",   {3'b0, key_press},   {3'b0, m_press});
      checkOutput("cmp_key_release", {3'b0, key_release}, {3'b0, m_release});
      checkOutput("cmp_multi_key",   {3'b0, multi_key},   {3'b0, m_multi});
    end
  end

  always @(negedge clk) begin
    if (key_press === 1'b1)   press_cnt++;
    if (key_release === 1'b1) release_cnt++;
  end

  task automatic applyStimulus(input logic [7:0] keys, input logic sel);
    key_in       = keys;
    higher_8_sel = sel;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_index"},   key_index, 4'h0);
    checkOutput({tag, "_valid"},   {3'b0, key_valid},   4'h0);
    checkOutput({tag, "_press"},   {3'b0, key_press},   4'h0);
    checkOutput({tag, "_release"}, {3'b0, key_release}, 4'h0);
    checkOutput({tag, "_multi"},   {3'b0, multi_key},   4'h0);
  endtask

  initial begin
    int p0;
    int r0;

    // Power-on reset
    rst = 1'b1;
    applyStimulus(8'h00, 1'b0);
    waitCycles(3);
    checkAllZero("reset");
    rst   = 1'b0;
    armed = 1'b1;
    waitCycles(10);

    // Single press and release
    $display("[TB] single press");
    applyStimulus(8'h04, 1'b0);
    waitCycles(7);
    checkOutput("press_early", {3'b0, key_press}, 4'h0);
    waitCycles(1);
    checkOutput("press_pulse", {3'b0, key_press}, 4'h1);
    checkOutput("press_index", key_index, 4'h2);
    checkOutput("press_valid", {3'b0, key_valid}, 4'h1);
    waitCycles(1);
    checkOutput("press_one_cycle", {3'b0, key_press}, 4'h0);
    waitCycles(10);
    applyStimulus(8'h00, 1'b0);
    waitCycles(8);
    checkOutput("release_pulse", {3'b0, key_release}, 4'h1);
    checkOutput("release_valid", {3'b0, key_valid}, 4'h0);
    checkOutput("release_index_kept", key_index, 4'h2);
    waitCycles(10);

    // Bounce
    $display("[TB] bounce");
    p0 = press_cnt;
    for (int i = 0; i < 5; i++) begin
      applyStimulus((i % 2 == 1) ? 8'h10 : 8'h00, 1'b0);
      waitCycles(2);
    end
    applyStimulus(8'h10, 1'b0);
    waitCycles(20);
    checkCount("bounce_press_count", press_cnt - p0, 1);
    checkOutput("bounce_index", key_index, 4'h4);
    checkOutput("bounce_valid", {3'b0, key_valid}, 4'h1);
    applyStimulus(8'h00, 1'b0);
    waitCycles(15);
    checkOutput("bounce_released", {3'b0, key_valid}, 4'h0);

    // Bank flip while holding key 7
    $display("[TB] bank flip");
    applyStimulus(8'h80, 1'b0);
    waitCycles(15);
    checkOutput("flip_before_index", key_index, 4'h7);
    applyStimulus(8'h80, 1'b1);
    waitCycles(8);
    checkOutput("flip_press",   {3'b0, key_press},   4'h1);
    checkOutput("flip_release", {3'b0, key_release}, 4'h1);
    checkOutput("flip_index",   key_index, 4'hF);
    checkOutput("flip_valid",   {3'b0, key_valid},   4'h1);
    waitCycles(1);
    checkOutput("flip_pulses_end", {2'b0, key_press, key_release}, 4'h0);
    waitCycles(10);
    applyStimulus(8'h00, 1'b0);
    waitCycles(15);

    // Two keys at once
    $display("[TB] two keys");
    p0 = press_cnt;
    applyStimulus(8'h0A, 1'b0);
    waitCycles(15);
`ifdef KEY_MULTI_ERR_EN
    checkOutput("multi_flag",  {3'b0, multi_key}, 4'h1);
    checkOutput("multi_valid", {3'b0, key_valid}, 4'h0);
    checkCount("multi_no_press", press_cnt - p0, 0);
`else
    checkOutput("multi_index", key_index, 4'h1);
    checkOutput("multi_valid", {3'b0, key_valid}, 4'h1);
    checkOutput("multi_flag",  {3'b0, multi_key}, 4'h0);
`endif
    applyStimulus(8'h00, 1'b0);
    waitCycles(15);
    checkOutput("multi_cleared", {3'b0, multi_key}, 4'h0);

    // Key change without release
    $display("[TB] key change");
    applyStimulus(8'h01, 1'b0);
    waitCycles(15);
    checkOutput("change_before_index", key_index, 4'h0);
    applyStimulus(8'h02, 1'b0);
    waitCycles(8);
    checkOutput("change_press",   {3'b0, key_press},   4'h1);
    checkOutput("change_release", {3'b0, key_release}, 4'h1);
    checkOutput("change_index",   key_index, 4'h1);
    checkOutput("change_valid",   {3'b0, key_valid},   4'h1);
    waitCycles(1);
    checkOutput("change_pulses_end", {2'b0, key_press, key_release}, 4'h0);
    checkOutput("change_valid_kept", {3'b0, key_valid}, 4'h1);

    // Short glitch while held
    $display("[TB] glitch");
    r0 = release_cnt;
    applyStimulus(8'h00, 1'b0);
    waitCycles(2);
    applyStimulus(8'h02, 1'b0);
    waitCycles(12);
    checkCount("glitch_no_release", release_cnt - r0, 0);
    checkOutput("glitch_valid", {3'b0, key_valid}, 4'h1);

    // Reset mid-hold
    $display("[TB] reset mid-hold");
    r0  = release_cnt;
    rst = 1'b1;
    #1;
    checkAllZero("midreset");
    @(negedge clk);
    #1;
    rst = 1'b0;
    waitCycles(7);
    checkOutput("rearm_early", {3'b0, key_press}, 4'h0);
    checkCount("midreset_no_release", release_cnt - r0, 0);
    waitCycles(1);
    checkOutput("rearm_press", {3'b0, key_press}, 4'h1);
    checkOutput("rearm_index", key_index, 4'h1);
    checkOutput("rearm_valid", {3'b0, key_valid}, 4'h1);
    waitCycles(10);
    applyStimulus(8'h00, 1'b0);
    waitCycles(15);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
